idli_decode_ser_m: RTL

- Parametrised serial instruction decoder for the idli core.
- Accepts instruction words LANE_W bits per cycle, LSB-first, and assembles INSTR_W-bit words.
- When the decoded word requests it, also collects a trailing INSTR_W-bit immediate word.
- Presents the decoded result on a valid/ready interface to the execute stage. Supports flush and input back-pressure.

---
 rtl/idli_decode_ser_m.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/idli_decode_ser_m.sv
// Serial instruction decoder for the idli core.
// Assembles an instruction word from LSB-first lane beats, optionally collects
// a trailing immediate word, decodes the ALU op and holds the result on a
// valid/ready handshake until the execute stage takes it.
module idli_decode_ser_m #(
  parameter int LANE_W  = 4,
  parameter int INSTR_W = 16,
  parameter bit IMM_EN  = 1'b1
) (
  input  logic               i_dcd_gck,
  input  logic               i_dcd_rst_n,
  input  logic               i_dcd_flush,
  input  logic [LANE_W-1:0]  i_dcd_enc,
  input  logic               i_dcd_enc_vld,
  output logic               o_dcd_enc_rdy,
  output logic               o_dcd_vld,
  input  logic               i_dcd_rdy,
  output logic [INSTR_W-1:0] o_dcd_word,
  output logic [INSTR_W-1:0] o_dcd_imm,
  output logic               o_dcd_has_imm,
  output logic [1:0]         o_dcd_alu_op
);

  localparam int N     = INSTR_W / LANE_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    WORD = 2'd0,
    IMM  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [INSTR_W-1:0] word_reg, word_next;
  logic [INSTR_W-1:0] imm_reg, imm_next;
  logic               has_imm_reg, has_imm_next;
  logic [1:0]         alu_reg, alu_next;
  logic               vld_reg, vld_next;

  // Word/immediate images with the incoming beat already merged in, so the
  // final-beat decode sees the complete word in the same cycle.
  logic [INSTR_W-1:0] word_asm;
  logic [INSTR_W-1:0] imm_asm;
  logic               accept;
  logic               last_beat;
  logic               asm_has_imm;

  // Beats are only taken while collecting; HOLD stalls the serial input.
  assign o_dcd_enc_rdy = (state_reg != HOLD);
  assign accept        = i_dcd_enc_vld && o_dcd_enc_rdy;
  assign last_beat     = (cnt_reg == LAST_IDX);
  assign asm_has_imm   = IMM_EN && (word_asm[4:2] == 3'b111);

  // Per-lane slice merge: only the lane selected by the beat counter can take
  // i_dcd_enc, so an idle/garbage input never reaches the stored words.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic lane_hit;
    assign lane_hit = accept && (cnt_reg == CNT_W'(gi));
    assign word_asm[gi*LANE_W +: LANE_W] = (lane_hit && state_reg == WORD) ?
                                           i_dcd_enc : word_reg[gi*LANE_W +: LANE_W];
    assign imm_asm[gi*LANE_W +: LANE_W]  = (lane_hit && state_reg == IMM) ?
                                           i_dcd_enc : imm_reg[gi*LANE_W +: LANE_W];
  end

  // ALU op: only class 10 carries a real op, selected by word[7:5].
  function automatic logic [1:0] decode_alu(input logic [INSTR_W-1:0] w);
    logic [1:0] op;
    op = 2'd0;
    if (w[1:0] == 2'b10) begin
      case (w[7:5])
        3'b010, 3'b011: op = 2'd1;
        3'b100:         op = 2'd2;
        3'b101:         op = 2'd3;
        default:        op = 2'd0;
      endcase
    end
    return op;
  endfunction

  // State and datapath registers; asynchronous clear to the idle decode state.
  always_ff @(posedge i_dcd_gck or negedge i_dcd_rst_n) begin
    if (!i_dcd_rst_n) begin
      state_reg   <= WORD;
      cnt_reg     <= '0;
      word_reg    <= '0;
      imm_reg     <= '0;
      has_imm_reg <= 1'b0;
      alu_reg     <= 2'd0;
      vld_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      word_reg    <= word_next;
      imm_reg     <= imm_next;
      has_imm_reg <= has_imm_next;
      alu_reg     <= alu_next;
      vld_reg     <= vld_next;
    end
  end

  // Next-state and datapath update; flush overrides every other event.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    word_next    = word_reg;
    imm_next     = imm_reg;
    has_imm_next = has_imm_reg;
    alu_next     = alu_reg;
    vld_next     = vld_reg;

    if (i_dcd_flush) begin
      state_next   = WORD;
      cnt_next     = '0;
      vld_next     = 1'b0;
      has_imm_next = 1'b0;
    end else begin
      case (state_reg)
        WORD: begin
          if (accept) begin
            word_next = word_asm;
            cnt_next  = last_beat ? '0 : cnt_reg + 1'b1;
            if (last_beat) begin
              imm_next     = '0;
              has_imm_next = asm_has_imm;
              alu_next     = decode_alu(word_asm);
              if (asm_has_imm) begin
                state_next = IMM;
              end else begin
                state_next = HOLD;
                vld_next   = 1'b1;
              end
            end
          end
        end
        IMM: begin
          if (accept) begin
            imm_next = imm_asm;
            cnt_next = last_beat ? '0 : cnt_reg + 1'b1;
            if (last_beat) begin
              state_next = HOLD;
              vld_next   = 1'b1;
            end
          end
        end
        HOLD: begin
          if (i_dcd_rdy) begin
            state_next = WORD;
            vld_next   = 1'b0;
          end
        end
        default: begin
          state_next = WORD;
          cnt_next   = '0;
          vld_next   = 1'b0;
        end
      endcase
    end
  end

  assign o_dcd_vld     = vld_reg;
  assign o_dcd_word    = word_reg;
  assign o_dcd_imm     = imm_reg;
  assign o_dcd_has_imm = has_imm_reg;
  assign o_dcd_alu_op  = alu_reg;

endmodule
